multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 39 +++
 rtl/multicycle_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_if
//  Brief    : Instruction/status inputs and datapath control outputs of the
//             multicycle controller.
//  Revision : 1.0
// ============================================================================
interface multicycle_ctrl_if;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        pc_we;
    logic        ir_we;
    logic        mem_re;
    logic        mem_we;
    logic        reg_we;
    logic        regrt;
    logic        mem_to_reg;
    logic        illegal;
    logic [2:0]  aluop;
    logic [1:0]  alusrc_b;
    logic [1:0]  pc_src;
    logic [2:0]  state;
    logic [15:0] retired;

    modport master (
        output op, funct, zero, mem_ready,
        input  pc_we, ir_we, mem_re, mem_we, reg_we, regrt, mem_to_reg,
               illegal, aluop, alusrc_b, pc_src, state, retired
    );

    modport slave (
        input  op, funct, zero, mem_ready,
        output pc_we, ir_we, mem_re, mem_we, reg_we, regrt, mem_to_reg,
               illegal, aluop, alusrc_b, pc_src, state, retired
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Brief    : Multicycle MIPS-subset control FSM with retired-instruction count.
//  Revision : 1.0
// ============================================================================
module multicycle_ctrl (
    input  wire logic         clk,
    input  wire logic         rst_n,
    multicycle_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    localparam logic [2:0] c_cls_r    = 3'd0;
    localparam logic [2:0] c_cls_lw   = 3'd1;
    localparam logic [2:0] c_cls_sw   = 3'd2;
    localparam logic [2:0] c_cls_beq  = 3'd3;
    localparam logic [2:0] c_cls_addi = 3'd4;
    localparam logic [2:0] c_cls_j    = 3'd5;
    localparam logic [2:0] c_cls_bad  = 3'd7;

    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_slt = 3'b100;

    localparam logic [1:0] c_srcb_reg   = 2'd0;
    localparam logic [1:0] c_srcb_four  = 2'd1;
    localparam logic [1:0] c_srcb_imm   = 2'd2;
    localparam logic [1:0] c_srcb_shimm = 2'd3;

    localparam logic [1:0] c_pc_alu    = 2'd0;
    localparam logic [1:0] c_pc_branch = 2'd1;
    localparam logic [1:0] c_pc_jump   = 2'd2;

    function automatic logic [2:0] classify(input logic [5:0] f_op, input logic [5:0] f_funct);
        logic [2:0] cls;
        cls = c_cls_bad;
        case (f_op)
            6'h00: begin
                case (f_funct)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: cls = c_cls_r;
                    default:                           cls = c_cls_bad;
                endcase
            end
            6'h23:   cls = c_cls_lw;
            6'h2B:   cls = c_cls_sw;
            6'h04:   cls = c_cls_beq;
            6'h08:   cls = c_cls_addi;
            6'h02:   cls = c_cls_j;
            default: cls = c_cls_bad;
        endcase
        return cls;
    endfunction

    function automatic logic [2:0] alu_of_funct(input logic [5:0] f_funct);
        logic [2:0] alu;
        case (f_funct)
            6'h22:   alu = c_alu_sub;
            6'h24:   alu = c_alu_and;
            6'h25:   alu = c_alu_or;
            6'h2A:   alu = c_alu_slt;
            default: alu = c_alu_add;
        endcase
        return alu;
    endfunction

    state_t      r_state;
    logic [5:0]  r_op;
    logic [5:0]  r_funct;
    logic [15:0] r_retired;

    state_t      w_next;
    logic [2:0]  w_live_cls;
    logic [2:0]  w_cls;
    logic        w_retire;
    logic        w_pc_we, w_ir_we, w_mem_re, w_mem_we, w_reg_we;
    logic        w_regrt, w_mem_to_reg, w_illegal;
    logic [2:0]  w_aluop;
    logic [1:0]  w_alusrc_b, w_pc_src;

    // DECODE branches on the live fields; the captured copy is only valid afterwards.
    assign w_live_cls = classify(bus.op, bus.funct);
    assign w_cls      = classify(r_op, r_funct);

    always_comb begin
        w_pc_we      = 1'b0;
        w_ir_we      = 1'b0;
        w_mem_re     = 1'b0;
        w_mem_we     = 1'b0;
        w_reg_we     = 1'b0;
        w_regrt      = 1'b0;
        w_mem_to_reg = 1'b0;
        w_illegal    = 1'b0;
        w_aluop      = c_alu_add;
        w_alusrc_b   = c_srcb_reg;
        w_pc_src     = c_pc_alu;
        w_next       = ST_FETCH;
        case (r_state)
            ST_FETCH: begin
                w_mem_re   = 1'b1;
                w_alusrc_b = c_srcb_four;
                w_ir_we    = bus.mem_ready;
                w_pc_we    = bus.mem_ready;
                w_next     = bus.mem_ready ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                w_alusrc_b = c_srcb_shimm;
                if (w_live_cls == c_cls_j) begin
                    w_pc_we  = 1'b1;
                    w_pc_src = c_pc_jump;
                    w_next   = ST_FETCH;
                end else if (w_live_cls == c_cls_bad) begin
                    w_next = ST_TRAP;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (w_cls)
                    c_cls_r: begin
                        w_aluop = alu_of_funct(r_funct);
                        w_next  = ST_WB;
                    end
                    c_cls_lw, c_cls_sw: begin
                        w_alusrc_b = c_srcb_imm;
                        w_next     = ST_MEM;
                    end
                    c_cls_addi: begin
                        w_alusrc_b = c_srcb_imm;
                        w_next     = ST_WB;
                    end
                    c_cls_beq: begin
                        w_aluop  = c_alu_sub;
                        w_pc_src = c_pc_branch;
                        w_pc_we  = bus.zero;
                        w_next   = ST_FETCH;
                    end
                    default: w_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (w_cls == c_cls_lw) begin
                    w_mem_re = 1'b1;
                    w_next   = bus.mem_ready ? ST_WB : ST_MEM;
                end else if (w_cls == c_cls_sw) begin
                    w_mem_we = 1'b1;
                    w_next   = bus.mem_ready ? ST_FETCH : ST_MEM;
                end else begin
                    w_next = ST_FETCH;
                end
            end
            ST_WB: begin
                w_reg_we     = 1'b1;
                w_regrt      = (w_cls != c_cls_r);
                w_mem_to_reg = (w_cls == c_cls_lw);
                w_next       = ST_FETCH;
            end
            ST_TRAP: begin
                w_illegal = 1'b1;
                w_next    = ST_TRAP;
            end
            default: w_next = ST_FETCH;
        endcase
    end

    // Unused encodings 5/6 return to FETCH without counting as a retirement.
    assign w_retire = ((r_state == ST_DECODE) || (r_state == ST_EXEC) ||
                       (r_state == ST_MEM)    || (r_state == ST_WB)) &&
                      (w_next == ST_FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_FETCH;
            r_op      <= 6'd0;
            r_funct   <= 6'd0;
            r_retired <= 16'd0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_op    <= bus.op;
                r_funct <= bus.funct;
            end
            if (w_retire) begin
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    // Enables are gated by rst_n so they drop while reset is held, whatever the state.
    assign bus.pc_we      = w_pc_we  & rst_n;
    assign bus.ir_we      = w_ir_we  & rst_n;
    assign bus.mem_re     = w_mem_re & rst_n;
    assign bus.mem_we     = w_mem_we & rst_n;
    assign bus.reg_we     = w_reg_we & rst_n;
    assign bus.regrt      = w_regrt;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.illegal    = w_illegal;
    assign bus.aluop      = w_aluop;
    assign bus.alusrc_b   = w_alusrc_b;
    assign bus.pc_src     = w_pc_src;
    assign bus.state      = r_state;
    assign bus.retired    = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Brief    : Directed per-cycle expectations queued by the driver, checked by a
//             negedge monitor.
//  Revision : 1.0
// ============================================================================
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        pc_we;
        logic        ir_we;
        logic        mem_re;
        logic        mem_we;
        logic        reg_we;
        logic        regrt;
        logic        mem_to_reg;
        logic        illegal;
        logic [2:0]  aluop;
        logic [1:0]  alusrc_b;
        logic [1:0]  pc_src;
        logic [15:0] retired;
    } obs_t;

    obs_t        exp_q[$];
    string       name_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_ret;

    obs_t  mon_e;
    obs_t  mon_a;
    string mon_n;

    // ---------------- expected-value builders ----------------
    function automatic obs_t blank(input logic [2:0] st);
        obs_t o;
        o         = '0;
        o.st      = st;
        o.retired = exp_ret;
        return o;
    endfunction

    function automatic obs_t e_reset();
        obs_t o;
        o          = '0;
        o.alusrc_b = 2'd1;
        return o;
    endfunction

    function automatic obs_t e_fetch(input logic mr);
        obs_t o;
        o          = blank(3'd0);
        o.mem_re   = 1'b1;
        o.alusrc_b = 2'd1;
        o.ir_we    = mr;
        o.pc_we    = mr;
        return o;
    endfunction

    function automatic obs_t e_dec(input logic is_j);
        obs_t o;
        o          = blank(3'd1);
        o.alusrc_b = 2'd3;
        o.pc_we    = is_j;
        o.pc_src   = is_j ? 2'd2 : 2'd0;
        return o;
    endfunction

    function automatic obs_t e_exr(input logic [2:0] aluop);
        obs_t o;
        o       = blank(3'd2);
        o.aluop = aluop;
        return o;
    endfunction

    function automatic obs_t e_exi();
        obs_t o;
        o          = blank(3'd2);
        o.alusrc_b = 2'd2;
        return o;
    endfunction

    function automatic obs_t e_exb(input logic z);
        obs_t o;
        o        = blank(3'd2);
        o.aluop  = 3'b001;
        o.pc_src = 2'd1;
        o.pc_we  = z;
        return o;
    endfunction

    function automatic obs_t e_mem(input logic is_lw);
        obs_t o;
        o        = blank(3'd3);
        o.mem_re = is_lw;
        o.mem_we = ~is_lw;
        return o;
    endfunction

    function automatic obs_t e_wb(input logic rt, input logic m2r);
        obs_t o;
        o            = blank(3'd4);
        o.reg_we     = 1'b1;
        o.regrt      = rt;
        o.mem_to_reg = m2r;
        return o;
    endfunction

    function automatic obs_t e_trap();
        obs_t o;
        o         = blank(3'd7);
        o.illegal = 1'b1;
        return o;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e            = exp_q.pop_front();
            mon_n            = name_q.pop_front();
            mon_a.st         = bus.state;
            mon_a.pc_we      = bus.pc_we;
            mon_a.ir_we      = bus.ir_we;
            mon_a.mem_re     = bus.mem_re;
            mon_a.mem_we     = bus.mem_we;
            mon_a.reg_we     = bus.reg_we;
            mon_a.regrt      = bus.regrt;
            mon_a.mem_to_reg = bus.mem_to_reg;
            mon_a.illegal    = bus.illegal;
            mon_a.aluop      = bus.aluop;
            mon_a.alusrc_b   = bus.alusrc_b;
            mon_a.pc_src     = bus.pc_src;
            mon_a.retired    = bus.retired;
            n_tests++;
            if (mon_a !== mon_e) begin
                n_fail++;
                $display("FAIL %s: got state=%0d retired=%h vec=%h, expected state=%0d retired=%h vec=%h",
                         mon_n, mon_a.st, mon_a.retired, mon_a, mon_e.st, mon_e.retired, mon_e);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: wait expired before the directed sequence finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------- direct reset-state check ----------------
    task automatic chk_reset(input string n);
        n_tests++;
        if ((bus.state !== 3'd0) || (bus.retired !== 16'd0) || (bus.illegal !== 1'b0) ||
            (bus.pc_we !== 1'b0) || (bus.ir_we !== 1'b0) || (bus.mem_re !== 1'b0) ||
            (bus.mem_we !== 1'b0) || (bus.reg_we !== 1'b0)) begin
            n_fail++;
            $display("FAIL %s: state=%0d retired=%h illegal=%b pc_we=%b ir_we=%b mem_re=%b mem_we=%b reg_we=%b",
                     n, bus.state, bus.retired, bus.illegal, bus.pc_we, bus.ir_we,
                     bus.mem_re, bus.mem_we, bus.reg_we);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input logic mr, input obs_t e, input string n);
        rst_n         = r;
        bus.op        = o;
        bus.funct     = f;
        bus.zero      = z;
        bus.mem_ready = mr;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    // mem_ready and zero wiggle outside FETCH/MEM/EXEC-beq and must be ignored.
    task automatic do_r(input logic [5:0] f, input logic [2:0] aluop, input string nm);
        step(1'b1, 6'h00, f, 1'b0, 1'b1, e_fetch(1'b1), {nm, "_fetch"});
        step(1'b1, 6'h00, f, 1'b1, 1'b0, e_dec(1'b0),   {nm, "_decode"});
        step(1'b1, 6'h00, f, 1'b0, 1'b0, e_exr(aluop),  {nm, "_exec"});
        step(1'b1, 6'h00, f, 1'b1, 1'b0, e_wb(1'b0, 1'b0), {nm, "_wb"});
        exp_ret++;
    endtask

    task automatic do_addi();
        step(1'b1, 6'h08, 6'h15, 1'b0, 1'b1, e_fetch(1'b1), "addi_fetch");
        step(1'b1, 6'h08, 6'h15, 1'b0, 1'b1, e_dec(1'b0),   "addi_decode");
        step(1'b1, 6'h08, 6'h15, 1'b1, 1'b1, e_exi(),       "addi_exec");
        step(1'b1, 6'h08, 6'h15, 1'b0, 1'b1, e_wb(1'b1, 1'b0), "addi_wb");
        exp_ret++;
    endtask

    task automatic do_lw(input int stalls);
        step(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, e_fetch(1'b0), "lw_fetch_wait");
        step(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, e_fetch(1'b1), "lw_fetch");
        step(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, e_dec(1'b0),   "lw_decode");
        step(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, e_exi(),       "lw_exec");
        for (int i = 0; i < stalls; i++)
            step(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, e_mem(1'b1), "lw_mem_stall");
        step(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, e_mem(1'b1), "lw_mem_done");
        step(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, e_wb(1'b1, 1'b1), "lw_wb");
        exp_ret++;
    endtask

    task automatic do_sw(input int stalls);
        step(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, e_fetch(1'b1), "sw_fetch");
        step(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, e_dec(1'b0),   "sw_decode");
        step(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, e_exi(),       "sw_exec");
        for (int i = 0; i < stalls; i++)
            step(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, e_mem(1'b0), "sw_mem_stall");
        step(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, e_mem(1'b0), "sw_mem_done");
        exp_ret++;
    endtask

    task automatic do_beq(input logic z);
        step(1'b1, 6'h04, 6'h00, ~z, 1'b1, e_fetch(1'b1), "beq_fetch");
        step(1'b1, 6'h04, 6'h00, ~z, 1'b1, e_dec(1'b0),   "beq_decode");
        step(1'b1, 6'h04, 6'h00, z,  1'b1, e_exb(z),      "beq_exec");
        exp_ret++;
    endtask

    task automatic do_j();
        step(1'b1, 6'h02, 6'h00, 1'b0, 1'b1, e_fetch(1'b1), "j_fetch");
        step(1'b1, 6'h02, 6'h00, 1'b0, 1'b1, e_dec(1'b1),   "j_decode");
        exp_ret++;
    endtask

    task automatic do_trap(input logic [5:0] o, input logic [5:0] f, input string nm);
        step(1'b1, o, f, 1'b0, 1'b1, e_fetch(1'b1), {nm, "_fetch"});
        step(1'b1, o, f, 1'b0, 1'b1, e_dec(1'b0),   {nm, "_decode"});
        for (int i = 0; i < 20; i++)
            step(1'b1, o, f, i[0], ~i[1], e_trap(), {nm, "_hold"});
        exp_ret = 16'd0;
        step(1'b0, o, f, 1'b0, 1'b1, e_reset(), {nm, "_reset"});
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.op        = 6'd0;
        bus.funct     = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        exp_ret       = 16'd0;
        @(posedge clk);
        #1;
        step(1'b0, 6'h00, 6'h00, 1'b0, 1'b1, e_reset(), "reset_state");
        step(1'b0, 6'h2B, 6'h00, 1'b1, 1'b1, e_reset(), "reset_hold");
        chk_reset("reset_direct");

        do_r(6'h20, 3'b000, "add");
        do_r(6'h22, 3'b001, "sub");
        do_r(6'h24, 3'b010, "and");
        do_r(6'h25, 3'b011, "or");
        do_r(6'h2A, 3'b100, "slt");
        do_addi();
        do_lw(2);
        do_sw(0);
        do_beq(1'b1);
        do_beq(1'b0);
        do_j();

        do_trap(6'h3F, 6'h00, "trap_op");
        do_trap(6'h00, 6'h3F, "trap_funct");

        // Reset in the middle of a store: mem_we must fall immediately.
        step(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, e_fetch(1'b1), "swr_fetch");
        step(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, e_dec(1'b0),   "swr_decode");
        step(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, e_exi(),       "swr_exec");
        step(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, e_mem(1'b0),   "swr_mem");
        exp_ret = 16'd0;
        step(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, e_reset(),     "swr_reset_mid_mem");
        chk_reset("swr_reset_direct");
        do_sw(1);

        // Reset during write-back of a load.
        step(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, e_fetch(1'b1), "lwr_fetch");
        step(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, e_dec(1'b0),   "lwr_decode");
        step(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, e_exi(),       "lwr_exec");
        step(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, e_mem(1'b1),   "lwr_mem");
        exp_ret = 16'd0;
        step(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, e_reset(),     "lwr_reset_mid_wb");

        // Preload the counter near the top to exercise the 0xFFFF -> 0x0000 wrap.
        force dut.r_retired = 16'hFFFE;
        #1;
        release dut.r_retired;
        exp_ret = 16'hFFFE;
        do_j();
        do_j();
        do_j();
        do_r(6'h20, 3'b000, "add_after_wrap");
        step(1'b1, 6'h00, 6'h00, 1'b0, 1'b0, e_fetch(1'b0), "final_fetch");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        if (n_fail == 0)
            $display("[TB] PASS");
        else
            $display("[TB] FAIL");
        $finish;
    end

endmodule
`default_nettype wire
